alt_frame_ctrl: RTL and testbench

- Frame sequencer for the ambient-light/threshold statistics engine.
- Pairs the DVI (reference) and CCD (captured) RGB565 pixel streams beat-for-beat over valid/ready handshakes, and stamps each pair with raster coordinates.
- Presents one paired pixel per cycle on valid_o/syncX_o/syncY_o to the statistics datapath.
- After the datapath latency, signals frame completion and counts frames; detects stalls and mid-frame resynchronisation.

---
 rtl/alt_frame_ctrl.sv | 144 ++++++++++++++
 tb/tb_alt_frame_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alt_frame_ctrl.sv
// Frame sequencer for the ambient-light statistics engine: pairs DVI and CCD
// RGB565 streams, stamps raster coordinates, and reports frame completion.
module alt_frame_ctrl #(
  parameter int unsigned H_ACT     = 640,
  parameter int unsigned V_ACT     = 480,
  parameter int unsigned DRAIN_CYC = 2,
  parameter int unsigned STALL_MAX = 1024
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        enable_i,
  input  logic        frame_start_i,
  input  logic        dvi_valid_i,
  output logic        dvi_ready_o,
  input  logic [15:0] dvi_data_i,
  input  logic        ccd_valid_i,
  output logic        ccd_ready_o,
  input  logic [15:0] ccd_data_i,
  output logic        valid_o,
  output logic [9:0]  syncX_o,
  output logic [9:0]  syncY_o,
  output logic [15:0] dvi_pix_o,
  output logic [15:0] ccd_pix_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        err_o,
  output logic [15:0] frame_cnt_o
);

  typedef enum logic [1:0] {IDLE, ARMED, STREAM, DRAIN} state_t;

  localparam int unsigned SW = $clog2(STALL_MAX + 1);
  localparam int unsigned DW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [9:0]    X_LAST     = 10'(H_ACT - 1);
  localparam logic [9:0]    Y_LAST     = 10'(V_ACT - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC);

  state_t        state;
  logic [9:0]    x_cnt, y_cnt;
  logic [SW-1:0] stall_cnt;
  logic [DW-1:0] drain_cnt;

  logic       in_stream, fire, resync, last_pix;
  logic [9:0] cur_x, cur_y;

  always_comb begin
    in_stream = (state == STREAM);
    fire      = in_stream & dvi_valid_i & ccd_valid_i;
    resync    = in_stream & frame_start_i & ((x_cnt != '0) | (y_cnt != '0));
    // A fire coincident with resync is pixel (0,0) of the new frame.
    cur_x     = resync ? '0 : x_cnt;
    cur_y     = resync ? '0 : y_cnt;
    last_pix  = (cur_x == X_LAST) & (cur_y == Y_LAST);
  end

  assign dvi_ready_o = in_stream & ccd_valid_i;
  assign ccd_ready_o = in_stream & dvi_valid_i;

  always_ff @(posedge clk_25) begin
    if (reset) begin
      state        <= IDLE;
      x_cnt        <= '0;
      y_cnt        <= '0;
      stall_cnt    <= '0;
      drain_cnt    <= '0;
      valid_o      <= 1'b0;
      syncX_o      <= '0;
      syncY_o      <= '0;
      dvi_pix_o    <= '0;
      ccd_pix_o    <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
      frame_cnt_o  <= '0;
    end else begin
      valid_o      <= fire;
      frame_done_o <= 1'b0;
      err_o        <= resync;
      if (fire) begin
        syncX_o   <= cur_x;
        syncY_o   <= cur_y;
        dvi_pix_o <= dvi_data_i;
        ccd_pix_o <= ccd_data_i;
      end
      case (state)
        IDLE: if (enable_i) state <= ARMED;
        ARMED: begin
          if (!enable_i) begin
            state <= IDLE;
          end else if (frame_start_i) begin
            state     <= STREAM;
            busy_o    <= 1'b1;
            x_cnt     <= '0;
            y_cnt     <= '0;
            stall_cnt <= '0;
          end
        end
        STREAM: begin
          if (fire) begin
            stall_cnt <= '0;
            if (last_pix) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
              x_cnt     <= '0;
              y_cnt     <= '0;
            end else if (cur_x == X_LAST) begin
              x_cnt <= '0;
              y_cnt <= cur_y + 10'd1;
            end else begin
              x_cnt <= cur_x + 10'd1;
              y_cnt <= cur_y;
            end
          end else if (resync) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            stall_cnt <= '0;
          end else if (stall_cnt == STALL_LAST) begin
            err_o     <= 1'b1;
            state     <= enable_i ? ARMED : IDLE;
            busy_o    <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + SW'(1);
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - DW'(1);
          if (drain_cnt <= DW'(1)) begin
            drain_cnt    <= '0;
            frame_done_o <= 1'b1;
            frame_cnt_o  <= frame_cnt_o + 16'd1;
            state        <= enable_i ? ARMED : IDLE;
            busy_o       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alt_frame_ctrl.sv
// Directed bench for alt_frame_ctrl on a 4x2 raster with short drain/stall limits.
module tb_alt_frame_ctrl;

  logic        clk_25 = 1'b0;
  logic        reset, enable_i, frame_start_i;
  logic        dvi_valid_i, dvi_ready_o, ccd_valid_i, ccd_ready_o;
  logic [15:0] dvi_data_i, ccd_data_i;
  logic        valid_o, busy_o, frame_done_o, err_o;
  logic [9:0]  syncX_o, syncY_o;
  logic [15:0] dvi_pix_o, ccd_pix_o, frame_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #20 clk_25 = ~clk_25;

  alt_frame_ctrl #(.H_ACT(4), .V_ACT(2), .DRAIN_CYC(2), .STALL_MAX(8)) dut (
    .clk_25(clk_25), .reset(reset), .enable_i(enable_i), .frame_start_i(frame_start_i),
    .dvi_valid_i(dvi_valid_i), .dvi_ready_o(dvi_ready_o), .dvi_data_i(dvi_data_i),
    .ccd_valid_i(ccd_valid_i), .ccd_ready_o(ccd_ready_o), .ccd_data_i(ccd_data_i),
    .valid_o(valid_o), .syncX_o(syncX_o), .syncY_o(syncY_o),
    .dvi_pix_o(dvi_pix_o), .ccd_pix_o(ccd_pix_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .err_o(err_o), .frame_cnt_o(frame_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  // One paired transfer at linear raster index idx (x = idx%4, y = idx/4).
  task automatic beat(input int idx, input int tagn);
    logic [15:0] d, c;
    d = 16'(32'hA000 + tagn * 16 + idx);
    c = 16'(32'h5000 + tagn * 16 + idx);
    dvi_valid_i = 1'b1; ccd_valid_i = 1'b1;
    dvi_data_i = d; ccd_data_i = c;
    #1;
    check("dvi_ready_fire", dvi_ready_o, 1);
    check("ccd_ready_fire", ccd_ready_o, 1);
    tick();
    check("beat_valid", valid_o, 1);
    check("beat_x", syncX_o, idx % 4);
    check("beat_y", syncY_o, idx / 4);
    check("beat_dvi", dvi_pix_o, d);
    check("beat_ccd", ccd_pix_o, c);
  endtask

  task automatic drain_done(input logic [15:0] exp_cnt);
    dvi_valid_i = 1'b1; ccd_valid_i = 1'b1;
    #1;
    check("drain_dvi_ready", dvi_ready_o, 0);
    check("drain_ccd_ready", ccd_ready_o, 0);
    tick();
    check("drain_valid", valid_o, 0);
    check("drain_early_done", frame_done_o, 0);
    check("drain_busy", busy_o, 1);
    tick();
    check("done_pulse", frame_done_o, 1);
    check("frame_cnt", frame_cnt_o, exp_cnt);
    check("done_busy", busy_o, 0);
    dvi_valid_i = 1'b0; ccd_valid_i = 1'b0;
    tick();
    check("done_single", frame_done_o, 0);
  endtask

  task automatic start_frame();
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    check("start_busy", busy_o, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    logic cv;
    reset = 1'b1; enable_i = 1'b0; frame_start_i = 1'b0;
    dvi_valid_i = 1'b0; ccd_valid_i = 1'b0; dvi_data_i = '0; ccd_data_i = '0;
    tick(); tick();
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cnt", frame_cnt_o, 0);
    check("rst_err", err_o, 0);
    reset = 1'b0;

    // Nominal frame
    enable_i = 1'b1;
    tick();
    check("armed_not_busy", busy_o, 0);
    start_frame();
    for (int i = 0; i < 8; i++) beat(i, 1);
    drain_done(16'd1);

    // Backpressure: dvi always valid, ccd toggles
    start_frame();
    b = 0;
    for (int k = 0; k < 15; k++) begin
      cv = ((k % 2) == 0);
      dvi_valid_i = 1'b1; ccd_valid_i = cv;
      dvi_data_i = 16'(32'h3000 + k); ccd_data_i = 16'(32'h4000 + k);
      #1;
      check("bp_dvi_ready", dvi_ready_o, cv);
      check("bp_ccd_ready", ccd_ready_o, 1);
      tick();
      check("bp_valid", valid_o, cv);
      if (cv) begin
        check("bp_x", syncX_o, b % 4);
        check("bp_y", syncY_o, b / 4);
        check("bp_dvi", dvi_pix_o, 32'h3000 + k);
        check("bp_ccd", ccd_pix_o, 32'h4000 + k);
        b++;
      end else begin
        check("bp_hold_x", syncX_o, (b - 1) % 4);
        check("bp_hold_dvi", dvi_pix_o, 32'h3000 + k - 1);
      end
    end
    drain_done(16'd2);

    // Stall abort after 3 pixels
    start_frame();
    for (int i = 0; i < 3; i++) beat(i, 2);
    dvi_valid_i = 1'b1; ccd_valid_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8) check("stall_no_err", err_o, 0);
    end
    check("stall_err", err_o, 1);
    check("stall_busy", busy_o, 0);
    check("stall_no_done", frame_done_o, 0);
    check("stall_cnt_kept", frame_cnt_o, 2);
    dvi_valid_i = 1'b0;
    tick();
    check("stall_err_single", err_o, 0);
    start_frame();
    for (int i = 0; i < 8; i++) beat(i, 3);
    drain_done(16'd3);

    // Mid-frame resync coincident with a fire at pixel 5
    start_frame();
    for (int i = 0; i < 5; i++) beat(i, 4);
    frame_start_i = 1'b1;
    beat(0, 5);
    check("resync_err", err_o, 1);
    frame_start_i = 1'b0;
    beat(1, 5);
    check("resync_err_single", err_o, 0);
    for (int i = 2; i < 8; i++) beat(i, 5);
    drain_done(16'd4);

    // Enable drop mid-frame: frame completes, then IDLE
    start_frame();
    for (int i = 0; i < 3; i++) beat(i, 6);
    enable_i = 1'b0;
    for (int i = 3; i < 8; i++) beat(i, 6);
    drain_done(16'd5);
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    check("idle_ignores_start", busy_o, 0);
    tick();
    check("idle_stays", busy_o, 0);

    // Reset mid-frame
    enable_i = 1'b1;
    tick();
    start_frame();
    for (int i = 0; i < 3; i++) beat(i, 7);
    reset = 1'b1;
    dvi_valid_i = 1'b1; ccd_valid_i = 1'b1;
    tick();
    check("mrst_valid", valid_o, 0);
    check("mrst_x", syncX_o, 0);
    check("mrst_y", syncY_o, 0);
    check("mrst_dvi", dvi_pix_o, 0);
    check("mrst_ccd", ccd_pix_o, 0);
    check("mrst_busy", busy_o, 0);
    check("mrst_done", frame_done_o, 0);
    check("mrst_err", err_o, 0);
    check("mrst_cnt", frame_cnt_o, 0);
    check("mrst_dvi_ready", dvi_ready_o, 0);
    check("mrst_ccd_ready", ccd_ready_o, 0);
    reset = 1'b0;
    dvi_valid_i = 1'b0; ccd_valid_i = 1'b0;

    // Frame counter wrap
    force dut.frame_cnt_o = 16'hFFFF;
    tick();
    release dut.frame_cnt_o;
    tick();
    check("wrap_preload", frame_cnt_o, 16'hFFFF);
    start_frame();
    for (int i = 0; i < 8; i++) beat(i, 8);
    drain_done(16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
